// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES decryptor control slice.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_LOAD  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/aes_rnd_cnt.sv
// Loadable saturating up/down round counter; direction is latched on load
// and selects which end (NR counting up, 0 counting down) is terminal.
module aes_rnd_cnt
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             ld_up,
    input  logic [IDX_W-1:0] ld_val,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             tc_c
);

    logic up;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            up  <= 1'b0;
        end else if (ld) begin
            cnt <= ld_val;
            up  <= ld_up;
        end else if (en) begin
            if (up && (cnt != '1)) begin
                cnt <= cnt + IDX_W'(1);
            end else if (!up && (cnt != '0)) begin
                cnt <= cnt - IDX_W'(1);
            end
        end
    end

    assign tc_c = up ? (cnt == IDX_W'(NR)) : (cnt == '0);

endmodule

// File: rtl/aes_dec_ctrl.sv
// Sequencer for the AES decryptor: key expansion, initial load, ten inverse
// rounds and result handshake. No datapath lives here.
module aes_dec_ctrl
    import aes_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             NewKey,
    input  logic             Ack,
    output logic             Busy,
    output logic             Ry,
    output logic             KeyWe,
    output logic [IDX_W-1:0] KeyIdx,
    output logic             Ld,
    output logic             RndEn,
    output logic             LastRnd,
    output logic [IDX_W-1:0] SelKey
);

    state_t           state;
    logic             key_valid;
    logic             key_stale;
    logic             cnt_ld;
    logic             cnt_up;
    logic             cnt_en;
    logic [IDX_W-1:0] cnt_val;
    logic [IDX_W-1:0] cnt;
    logic             cnt_tc;

    aes_rnd_cnt u_cnt (
        .clk    (Clk),
        .rst    (Rst),
        .ld     (cnt_ld),
        .ld_up  (cnt_up),
        .ld_val (cnt_val),
        .en     (cnt_en),
        .cnt    (cnt),
        .tc_c   (cnt_tc)
    );

    // Counter tracks KeyIdx during KEXP (1..NR) and SelKey during ROUND (NR-1..0).
    always_comb begin
        cnt_ld  = 1'b0;
        cnt_up  = 1'b0;
        cnt_en  = 1'b0;
        cnt_val = '0;
        case (state)
            S_IDLE: begin
                if (Start && (!key_valid || NewKey)) begin
                    cnt_ld  = 1'b1;
                    cnt_up  = 1'b1;
                    cnt_val = IDX_W'(1);
                end
            end
            S_KEXP, S_ROUND: cnt_en = !cnt_tc;
            S_LOAD: begin
                cnt_ld  = 1'b1;
                cnt_val = IDX_W'(NR - 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            key_valid <= 1'b0;
            key_stale <= 1'b0;
            Busy      <= 1'b0;
            Ry        <= 1'b0;
            KeyWe     <= 1'b0;
            KeyIdx    <= '0;
            Ld        <= 1'b0;
            RndEn     <= 1'b0;
            LastRnd   <= 1'b0;
            SelKey    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        Busy <= 1'b1;
                        if (!key_valid || NewKey) begin
                            state  <= S_KEXP;
                            KeyWe  <= 1'b1;
                            KeyIdx <= IDX_W'(1);
                        end else begin
                            state  <= S_LOAD;
                            Ld     <= 1'b1;
                            SelKey <= IDX_W'(NR);
                        end
                    end else if (NewKey) begin
                        key_valid <= 1'b0;
                    end
                end
                S_KEXP: begin
                    if (NewKey) key_stale <= 1'b1;
                    if (cnt_tc) begin
                        state     <= S_LOAD;
                        key_valid <= 1'b1;
                        KeyWe     <= 1'b0;
                        KeyIdx    <= '0;
                        Ld        <= 1'b1;
                        SelKey    <= IDX_W'(NR);
                    end else begin
                        KeyIdx <= cnt + IDX_W'(1);
                    end
                end
                S_LOAD: begin
                    if (NewKey) key_stale <= 1'b1;
                    state   <= S_ROUND;
                    Ld      <= 1'b0;
                    RndEn   <= 1'b1;
                    SelKey  <= IDX_W'(NR - 1);
                    LastRnd <= 1'b0;
                end
                S_ROUND: begin
                    if (NewKey) key_stale <= 1'b1;
                    if (cnt_tc) begin
                        state   <= S_DONE;
                        RndEn   <= 1'b0;
                        LastRnd <= 1'b0;
                        SelKey  <= '0;
                        Busy    <= 1'b0;
                        Ry      <= 1'b1;
                    end else begin
                        SelKey  <= cnt - IDX_W'(1);
                        LastRnd <= (cnt == IDX_W'(1));
                    end
                end
                S_DONE: begin
                    // A key change seen at any point during the operation invalidates the store on exit.
                    if (Ack) begin
                        state     <= S_IDLE;
                        Ry        <= 1'b0;
                        key_stale <= 1'b0;
                        if (key_stale || NewKey) key_valid <= 1'b0;
                    end else if (NewKey) begin
                        key_stale <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    key_valid <= 1'b0;
                    key_stale <= 1'b0;
                    Busy      <= 1'b0;
                    Ry        <= 1'b0;
                    KeyWe     <= 1'b0;
                    KeyIdx    <= '0;
                    Ld        <= 1'b0;
                    RndEn     <= 1'b0;
                    LastRnd   <= 1'b0;
                    SelKey    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Self-checking bench for aes_dec_ctrl: directed scenarios plus randomized
// operations compared against a cycle-offset model of one decryption.
module tb_aes_dec_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic       NewKey;
    logic       Ack;
    logic       Busy;
    logic       Ry;
    logic       KeyWe;
    logic [3:0] KeyIdx;
    logic       Ld;
    logic       RndEn;
    logic       LastRnd;
    logic [3:0] SelKey;

    logic [13:0] obs;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          m_kv     = 1'b0;

    always #5 Clk = ~Clk;

    aes_dec_ctrl dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .NewKey  (NewKey),
        .Ack     (Ack),
        .Busy    (Busy),
        .Ry      (Ry),
        .KeyWe   (KeyWe),
        .KeyIdx  (KeyIdx),
        .Ld      (Ld),
        .RndEn   (RndEn),
        .LastRnd (LastRnd),
        .SelKey  (SelKey)
    );

    assign obs = {Busy, Ry, KeyWe, KeyIdx, Ld, RndEn, LastRnd, SelKey};

    // Expected outputs k cycles after Start is accepted.
    function automatic logic [13:0] exp_vec(input int k, input bit kexp);
        int         e;
        logic       busy, ry, we, ld, rnd, last;
        logic [3:0] idx, sel;
        e = kexp ? 10 : 0;
        busy = 0; ry = 0; we = 0; ld = 0; rnd = 0; last = 0; idx = 0; sel = 0;
        if (k >= 1 && k <= e) begin
            busy = 1; we = 1; idx = 4'(k);
        end else if (k == e + 1) begin
            busy = 1; ld = 1; sel = 4'd10;
        end else if (k >= e + 2 && k <= e + 11) begin
            busy = 1; rnd = 1; sel = 4'(e + 11 - k); last = (sel == 4'd0);
        end else if (k >= e + 12) begin
            ry = 1;
        end
        return {busy, ry, we, idx, ld, rnd, last, sel};
    endfunction

    // One operation; offsets are counted from the LOAD cycle (ROUND = 1..10, DONE = 11..).
    task automatic exec_op(input string name, input bit nk, input int s1, input int s2,
                           input int nk_off, input int ack_wait, input int rst_off, input bit noise);
        bit          kexp  = !m_kv || nk;
        int          e     = kexp ? 10 : 0;
        int          last  = e + 12 + ack_wait;
        bit          stale = 1'b0;
        bit          aborted = 1'b0;
        logic [13:0] exp;
        @(negedge Clk);
        Start = 1'b1; NewKey = nk; Ack = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge Clk);
            Start = 1'b0; NewKey = 1'b0; Ack = 1'b0;
            exp = exp_vec(k, kexp);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s cycle=%0d actual=%h expected=%h", name, k, obs, exp);
            end
            if (k - e - 1 == rst_off) begin
                Rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (k - e - 1 == s1 || k - e - 1 == s2 || (noise && $urandom_range(3) == 0)) Start = 1'b1;
            if (k - e - 1 == nk_off || (noise && $urandom_range(7) == 0)) begin
                NewKey = 1'b1;
                stale  = 1'b1;
            end
            if (noise && k < e + 12 && $urandom_range(3) == 0) Ack = 1'b1;
            if (k == last) Ack = 1'b1;
        end
        @(negedge Clk);
        Start = 1'b0; NewKey = 1'b0; Ack = 1'b0;
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL %s_exit actual=%h expected=%h", name, obs, 14'h0);
        end
        if (aborted) begin
            Rst  = 1'b0;
            m_kv = 1'b0;
        end else begin
            m_kv = !stale;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; NewKey = 1'b0; Ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if (obs !== 14'h0) begin
                n_fail++;
                $display("FAIL reset cycle=%0d actual=%h expected=%h", i, obs, 14'h0);
            end
        end
        Rst  = 1'b0;
        m_kv = 1'b0;
    endtask

    task automatic test_first_kexp();
        exec_op("first_kexp", 1'b1, -100, -100, -100, 0, -100, 1'b0);
    endtask

    task automatic test_valid_key();
        exec_op("valid_key", 1'b0, -100, -100, -100, 0, -100, 1'b0);
    endtask

    task automatic test_start_ignored();
        exec_op("start_ignored", 1'b0, 3, 7, -100, 0, -100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if (obs !== 14'h0) begin
                n_fail++;
                $display("FAIL start_queued cycle=%0d actual=%h expected=%h", i, obs, 14'h0);
            end
        end
    endtask

    task automatic test_newkey_in_round();
        exec_op("newkey_round", 1'b0, -100, -100, 4, 0, -100, 1'b0);
        exec_op("after_newkey", 1'b0, -100, -100, -100, 0, -100, 1'b0);
    endtask

    task automatic test_reset_mid_round();
        exec_op("rst_round", 1'b0, -100, -100, -100, 0, 5, 1'b0);
        exec_op("after_rst", 1'b0, -100, -100, -100, 0, -100, 1'b0);
    endtask

    task automatic test_ack_hold();
        exec_op("ack_hold", 1'b0, 14, 21, -100, 20, -100, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            n_checks++;
            if (obs !== 14'h0) begin
                n_fail++;
                $display("FAIL ack_hold_idle cycle=%0d actual=%h expected=%h", i, obs, 14'h0);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 30; n++) begin
            exec_op("random", ($urandom_range(3) == 0), -100, -100, -100,
                    int'($urandom_range(3)), -100, 1'b1);
            for (int g = 0; g < int'($urandom_range(3)); g++) begin
                @(negedge Clk);
                NewKey = 1'b0;
                n_checks++;
                if (obs !== 14'h0) begin
                    n_fail++;
                    $display("FAIL random_idle op=%0d actual=%h expected=%h", n, obs, 14'h0);
                end
                if ($urandom_range(2) == 0) begin
                    NewKey = 1'b1;
                    m_kv   = 1'b0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_kexp();
        test_valid_key();
        test_start_ignored();
        test_newkey_in_round();
        test_reset_mid_round();
        test_ack_hold();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
